// File: rtl/sobel_gradient_calc.sv
// Sobel gradient magnitude (|Gx| + |Gy|, saturated to 8 bits) with edge flag for a 3x3 pixel window.
// Latency: 3 cycles from done_i to done_o; full throughput, one window per cycle.
// Backpressure: none; every accepted window produces exactly one result, idle cycles travel as bubbles.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   d0_i..d8_i    3x3 window, row-major: d0 d1 d2 / d3 d4 d5 / d6 d7 d8
//   done_i        window-valid strobe (one window per high cycle)
//   grad_o        saturated gradient magnitude, zero on border windows
//   edge_o        grad_o >= THRESHOLD, zero on border windows
//   done_o        result-valid strobe
//   frame_done_o  pulses with the result of the last window of a frame
module sobel_gradient_calc #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int THRESHOLD  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d0_i,
    input  logic [7:0] d1_i,
    input  logic [7:0] d2_i,
    input  logic [7:0] d3_i,
    input  logic [7:0] d4_i,
    input  logic [7:0] d5_i,
    input  logic [7:0] d6_i,
    input  logic [7:0] d7_i,
    input  logic [7:0] d8_i,
    input  logic       done_i,
    output logic [7:0] grad_o,
    output logic       edge_o,
    output logic       done_o,
    output logic       frame_done_o
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [7:0]       THR      = 8'(THRESHOLD);

    // Weighted 1-2-1 column/row sum; 255*4 = 1020 fits in 10 bits.
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // ------------------------------------------------------------------
    // Window position tracking
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;
    logic             border_in;
    logic             frame_last_in;

    assign col_last      = (col == COL_LAST);
    assign row_last      = (row == ROW_LAST);
    assign border_in     = (col == '0) || col_last || (row == '0) || row_last;
    assign frame_last_in = col_last && row_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (done_i) begin
            if (col_last) begin
                col <= '0;
                // End of frame wraps straight back to the origin so the next
                // frame can start on the very next cycle.
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: partial sums
    // ------------------------------------------------------------------
    logic [9:0] s1_gx_pos;
    logic [9:0] s1_gx_neg;
    logic [9:0] s1_gy_pos;
    logic [9:0] s1_gy_neg;
    logic       s1_vld;
    logic       s1_border;
    logic       s1_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_gx_pos <= '0;
            s1_gx_neg <= '0;
            s1_gy_pos <= '0;
            s1_gy_neg <= '0;
            s1_vld    <= 1'b0;
            s1_border <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            s1_vld <= done_i;
            if (done_i) begin
                s1_gx_pos <= wsum(d2_i, d5_i, d8_i);
                s1_gx_neg <= wsum(d0_i, d3_i, d6_i);
                s1_gy_pos <= wsum(d6_i, d7_i, d8_i);
                s1_gy_neg <= wsum(d0_i, d1_i, d2_i);
                s1_border <= border_in;
                s1_last   <= frame_last_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed gradients and their magnitudes
    // ------------------------------------------------------------------
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic        [10:0] abs_gx;
    logic        [10:0] abs_gy;

    // Zero-extend the 10-bit sums before subtracting so the difference
    // covers -1020..+1020 without wrapping.
    assign gx     = $signed({1'b0, s1_gx_pos}) - $signed({1'b0, s1_gx_neg});
    assign gy     = $signed({1'b0, s1_gy_pos}) - $signed({1'b0, s1_gy_neg});
    assign abs_gx = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    assign abs_gy = gy[10] ? $unsigned(-gy) : $unsigned(gy);

    logic [10:0] s2_abs_gx;
    logic [10:0] s2_abs_gy;
    logic        s2_vld;
    logic        s2_border;
    logic        s2_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_abs_gx <= '0;
            s2_abs_gy <= '0;
            s2_vld    <= 1'b0;
            s2_border <= 1'b0;
            s2_last   <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_abs_gx <= abs_gx;
                s2_abs_gy <= abs_gy;
                s2_border <= s1_border;
                s2_last   <= s1_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, saturation, border masking, threshold
    // ------------------------------------------------------------------
    logic [10:0] mag;
    logic [7:0]  mag_sat;
    logic [7:0]  grad_nxt;
    logic        edge_nxt;

    // Each magnitude is at most 1020, so the sum (max 2040) fits 11 bits.
    assign mag      = s2_abs_gx + s2_abs_gy;
    assign mag_sat  = (mag > 11'd255) ? 8'hFF : mag[7:0];
    assign grad_nxt = s2_border ? 8'h00 : mag_sat;
    assign edge_nxt = !s2_border && (mag_sat >= THR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grad_o       <= '0;
            edge_o       <= 1'b0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            done_o       <= s2_vld;
            frame_done_o <= s2_vld && s2_last;
            // Results only move on a valid slot; bubbles leave the last
            // result on the outputs.
            if (s2_vld) begin
                grad_o <= grad_nxt;
                edge_o <= edge_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_calc.sv
module tb_sobel_gradient_calc;

    logic       clk;
    logic       rst;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic       done_i;
    logic [7:0] grad_o;
    logic       edge_o;
    logic       done_o;
    logic       frame_done_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Window patterns, packed d0..d8 from MSB to LSB.
    localparam logic [71:0] STEP  = {8'd0, 8'd128, 8'd255,
                                     8'd0, 8'd128, 8'd255,
                                     8'd0, 8'd128, 8'd255};
    localparam logic [71:0] UNI   = {9{8'd100}};
    localparam logic [71:0] SMALL = {8'd0, 8'd0, 8'd10, 48'd0};

    sobel_gradient_calc #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(3),
        .THRESHOLD (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d0_i        (d0),
        .d1_i        (d1),
        .d2_i        (d2),
        .d3_i        (d3),
        .d4_i        (d4),
        .d5_i        (d5),
        .d6_i        (d6),
        .d7_i        (d7),
        .d8_i        (d8),
        .done_i      (done_i),
        .grad_o      (grad_o),
        .edge_o      (edge_o),
        .done_o      (done_o),
        .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // Expected-result delay line: entry 2 is what must appear on the outputs now.
    logic       exp_v [3];
    logic [7:0] exp_g [3];
    logic       exp_e [3];
    logic       exp_f [3];
    logic [7:0] held_g;
    logic       held_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 3; i++) begin
            exp_v[i] = 1'b0;
            exp_g[i] = 8'd0;
            exp_e[i] = 1'b0;
            exp_f[i] = 1'b0;
        end
        held_g = 8'd0;
        held_e = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " done_o"},       32'(done_o),       32'(exp_v[2]));
        chk({tag, " grad_o"},       32'(grad_o),       32'(held_g));
        chk({tag, " edge_o"},       32'(edge_o),       32'(held_e));
        chk({tag, " frame_done_o"}, 32'(frame_done_o), 32'(exp_v[2] & exp_f[2]));
    endtask

    // One clock: present a window (or a bubble), then check outputs at the
    // following falling edge. eg/ee/ef are the hand-computed results for it.
    task automatic cyc(input string tag, input logic v, input logic [71:0] win,
                       input logic [7:0] eg, input logic ee, input logic ef);
        done_i = v;
        {d0, d1, d2, d3, d4, d5, d6, d7, d8} = win;
        @(negedge clk);
        for (int i = 2; i > 0; i--) begin
            exp_v[i] = exp_v[i-1];
            exp_g[i] = exp_g[i-1];
            exp_e[i] = exp_e[i-1];
            exp_f[i] = exp_f[i-1];
        end
        exp_v[0] = v;
        exp_g[0] = eg;
        exp_e[0] = ee;
        exp_f[0] = ef;
        if (exp_v[2]) begin
            held_g = exp_g[2];
            held_e = exp_e[2];
        end
        check_outputs(tag);
    endtask

    initial begin
        rst    = 1'b0;
        done_i = 1'b0;
        {d0, d1, d2, d3, d4, d5, d6, d7, d8} = 72'd0;
        clear_exp();

        // Reset state
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;

        // Frame 1: 12 back-to-back vertical-step windows; only (1,1) and
        // (2,1) are interior and give Gx=1020 -> 255 with edge.
        for (int i = 0; i < 12; i++) begin
            if (i == 5 || i == 6) cyc("f1_step_interior", 1'b1, STEP, 8'd255, 1'b1, 1'b0);
            else                  cyc("f1_step_border",   1'b1, STEP, 8'd0,   1'b0, i == 11);
        end

        // Frame 2 follows with no gap: first window wraps to (0,0) -> border 0.
        // (1,1) uniform -> 0; (2,1) small gradient Gx=10,Gy=-10 -> 20, no edge.
        for (int i = 0; i < 12; i++) begin
            if (i == 5)      cyc("f2_uniform", 1'b1, UNI,   8'd0,  1'b0, 1'b0);
            else if (i == 6) cyc("f2_small",   1'b1, SMALL, 8'd20, 1'b0, 1'b0);
            else             cyc("f2_border",  1'b1, STEP,  8'd0,  1'b0, i == 11);
        end

        // Frame 3: done_i toggles 1,0,1,0 over the interior windows; the
        // outputs must hold 255 then 20 through the bubbles.
        for (int i = 0; i < 5; i++) cyc("f3_border", 1'b1, STEP, 8'd0, 1'b0, 1'b0);
        cyc("f3_tog_step",   1'b1, STEP,  8'd255, 1'b1, 1'b0);
        cyc("f3_tog_bubble", 1'b0, UNI,   8'd0,   1'b0, 1'b0);
        cyc("f3_tog_small",  1'b1, SMALL, 8'd20,  1'b0, 1'b0);
        cyc("f3_tog_bubble", 1'b0, UNI,   8'd0,   1'b0, 1'b0);
        cyc("f3_pre_rst",    1'b1, STEP,  8'd0,   1'b0, 1'b0);
        cyc("f3_pre_rst",    1'b1, STEP,  8'd0,   1'b0, 1'b0);

        // Reset one cycle after two pulses, mid-cycle with no clock edge:
        // outputs clear at once and both windows in flight are dropped.
        done_i = 1'b0;
        rst    = 1'b0;
        #1;
        clear_exp();
        check_outputs("async_rst");

        // done_i is ignored while reset is held.
        done_i = 1'b1;
        {d0, d1, d2, d3, d4, d5, d6, d7, d8} = STEP;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_outputs("rst_hold");
        end
        done_i = 1'b0;
        rst    = 1'b1;

        // Nothing from before the reset may emerge.
        for (int i = 0; i < 3; i++) cyc("post_rst_idle", 1'b0, UNI, 8'd0, 1'b0, 1'b0);

        // Restart at (0,0): border windows give 0, then (1,1) step gives 255.
        for (int i = 0; i < 5; i++) cyc("f4_border", 1'b1, STEP, 8'd0, 1'b0, 1'b0);
        cyc("f4_step_interior", 1'b1, STEP, 8'd255, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc("f4_drain", 1'b0, UNI, 8'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_gradient_calc.md
SOBEL_GRADIENT_CALC -- requirements
Module: sobel_gradient_calc

Interface
REQ-001 SHALL provide parameter IMG_WIDTH, default 640, windows per line.
REQ-002 SHALL provide parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 SHALL provide parameter THRESHOLD, default 100, 8-bit edge threshold.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports d0_i..d8_i, input, 8 each, 3x3 window: d0 d1 d2 top row, d3 d4 d5 middle row, d6 d7 d8 bottom row, left to right.
REQ-007 SHALL have port done_i, input, 1, window-valid strobe, one window per high cycle.
REQ-008 SHALL have port grad_o, output, 8, saturated gradient magnitude.
REQ-009 SHALL have port edge_o, output, 1, edge flag.
REQ-010 SHALL have port done_o, output, 1, result-valid strobe.
REQ-011 SHALL have port frame_done_o, output, 1, last-result-of-frame strobe.

Function
REQ-012 SHALL compute Gx = (d2 + 2*d5 + d8) - (d0 + 2*d3 + d6).
REQ-013 SHALL compute Gy = (d6 + 2*d7 + d8) - (d0 + 2*d1 + d2).
REQ-014 SHALL keep partial sums 10-bit unsigned and Gx/Gy 11-bit signed (range -1020..+1020), with no overflow.
REQ-015 SHALL form mag = |Gx| + |Gy| as 11-bit unsigned (0..2040), and set grad_o = 255 when mag > 255, else mag[7:0].
REQ-016 SHALL drive edge_o = 1 when grad_o >= THRESHOLD, else 0.
REQ-017 SHALL use a 3-stage pipeline: S1 registers partial sums, S2 registers |Gx| and |Gy|, S3 registers grad_o, edge_o and done_o.
REQ-018 SHALL drive done_o high exactly 3 cycles after each done_i high cycle.
REQ-019 SHALL accept done_i on consecutive cycles at full throughput; there is no backpressure.
REQ-020 SHALL register data only on done_i=1; cycles with done_i=0 insert bubbles carried through the valid shift chain.
REQ-021 SHALL hold grad_o and edge_o at their last values while done_o=0.
REQ-022 SHALL maintain col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters, advanced once per done_i.
REQ-023 SHALL wrap col from IMG_WIDTH-1 to 0 and increment row at the same time.
REQ-024 SHALL wrap row from IMG_HEIGHT-1 to 0 when col also wraps (end of frame).
REQ-025 SHALL force grad_o=0 and edge_o=0 for border windows (col==0, col==IMG_WIDTH-1, row==0 or row==IMG_HEIGHT-1); the border flag travels with the window through the pipeline.
REQ-026 SHALL pulse frame_done_o for one cycle, coincident with the done_o of the window at col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
REQ-027 SHALL start the next frame at col=0, row=0 with no idle cycle required.

Reset
REQ-028 SHALL, on rst=0 and independent of clk, clear grad_o, edge_o, done_o, frame_done_o, col, row, all pipeline valid bits and all data registers to 0.
REQ-029 SHALL discard windows in flight when reset asserts mid-frame; after release the first done_i is treated as col=0, row=0.
REQ-030 SHALL ignore done_i while rst=0.

Verification (bench parameters IMG_WIDTH=4, IMG_HEIGHT=3, THRESHOLD=100)
REQ-031 SHALL cover a uniform interior window (all inputs 100, col=1, row=1) -> grad_o=0, edge_o=0, done_o high 3 cycles after done_i.
REQ-032 SHALL cover a vertical step interior window (d0,d3,d6=0; d2,d5,d8=255; others 128) -> Gx=1020, Gy=0, grad_o=255, edge_o=1.
REQ-033 SHALL cover a small-gradient interior window (d2=10, all others 0) -> Gx=10, Gy=-10, grad_o=20, edge_o=0.
REQ-034 SHALL cover 12 back-to-back windows with the vertical step pattern -> only windows 6 and 7 give grad_o=255; all others give 0; frame_done_o pulses only with result 12; window 13 is treated as col=0, row=0.
REQ-035 SHALL cover reset asserted 1 cycle after 2 done_i pulses -> no done_o appears; after release, the next window gives border output 0 (col=0, row=0).
REQ-036 SHALL cover done_i toggling 1,0,1,0 -> done_o reproduces the same pattern delayed 3 cycles, and grad_o holds its value during bubble cycles.
